// File: rtl/counter_seq_monitor_if.sv
// Bundle between an observed up-counter and its sequence monitor; cnt_en exists only with CNT_MON_HOLD_EN.
// master drives the observed counter signals and clr, slave is the monitor producing the status outputs.
interface counter_seq_monitor_if #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
);
  logic [WIDTH-1:0]      cnt_in;
  logic                  cnt_rst;
  logic                  clr;
`ifdef CNT_MON_HOLD_EN
  logic                  cnt_en;
`endif
  logic                  locked;
  logic                  err_pulse;
  logic                  err_sticky;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0]      rise_seen;
  logic [WIDTH-1:0]      fall_seen;
  logic                  full_toggle;

`ifdef CNT_MON_HOLD_EN
  modport master (
    output cnt_in, cnt_rst, clr, cnt_en,
    input  locked, err_pulse, err_sticky, err_count, wrap_count,
           rise_seen, fall_seen, full_toggle
  );
  modport slave (
    input  cnt_in, cnt_rst, clr, cnt_en,
    output locked, err_pulse, err_sticky, err_count, wrap_count,
           rise_seen, fall_seen, full_toggle
  );
`else
  modport master (
    output cnt_in, cnt_rst, clr,
    input  locked, err_pulse, err_sticky, err_count, wrap_count,
           rise_seen, fall_seen, full_toggle
  );
  modport slave (
    input  cnt_in, cnt_rst, clr,
    output locked, err_pulse, err_sticky, err_count, wrap_count,
           rise_seen, fall_seen, full_toggle
  );
`endif
endinterface

// File: rtl/counter_seq_monitor.sv
// Passive up-counter sequence checker; CNT_MON_HOLD_EN adds cnt_en so held values are legal.
// Outputs are registered, visible one cycle after the sampled edge; never applies backpressure.
module counter_seq_monitor #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_seq_monitor_if.slave  mon
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  state_t                state;
  logic [WIDTH-1:0]      last_val;
  logic                  last_rst;
`ifdef CNT_MON_HOLD_EN
  logic                  last_en;
`endif
  logic                  locked;
  logic                  err_pulse;
  logic                  err_sticky;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0]      rise_seen;
  logic [WIDTH-1:0]      fall_seen;

  logic [WIDTH-1:0]      exp_val;
  logic                  advancing;
  logic                  mismatch;
  logic                  wrap_hit;
  logic [WIDTH-1:0]      rise_hit;
  logic [WIDTH-1:0]      fall_hit;

  always_comb begin
`ifdef CNT_MON_HOLD_EN
    advancing = last_en;
`else
    advancing = 1'b1;
`endif
    if (last_rst) begin
      exp_val = '0;
    end else if (advancing) begin
      exp_val = last_val + WIDTH'(1);
    end else begin
      exp_val = last_val;
    end
    mismatch = (state == LOCKED) && (mon.cnt_in != exp_val);
    // A return to zero forced by the counter's own reset is not a wrap.
    wrap_hit = (state == LOCKED) && !last_rst && advancing &&
               (last_val == MAX_VAL) && (mon.cnt_in == '0);
    rise_hit = '0;
    fall_hit = '0;
    if ((state == LOCKED) && advancing) begin
      rise_hit = ~last_val & mon.cnt_in;
      fall_hit = last_val & ~mon.cnt_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= UNLOCKED;
      last_val   <= '0;
      last_rst   <= 1'b0;
`ifdef CNT_MON_HOLD_EN
      last_en    <= 1'b0;
`endif
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      rise_seen  <= '0;
      fall_seen  <= '0;
    end else begin
      // Always re-seed from the sample, so one glitched value costs two errors.
      last_val <= mon.cnt_in;
      last_rst <= mon.cnt_rst;
`ifdef CNT_MON_HOLD_EN
      last_en  <= mon.cnt_en;
`endif
      case (state)
        UNLOCKED: begin
          if (!mon.cnt_rst) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          state  <= LOCKED;
          locked <= 1'b1;
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase

      if (mon.clr) begin
        err_pulse  <= 1'b0;
        err_sticky <= 1'b0;
        err_count  <= '0;
        wrap_count <= '0;
        rise_seen  <= '0;
        fall_seen  <= '0;
      end else begin
        err_pulse <= mismatch;
        if (mismatch) begin
          err_sticky <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + ERR_CNT_W'(1);
          end
        end
        if (wrap_hit && (wrap_count != '1)) begin
          wrap_count <= wrap_count + WRAP_CNT_W'(1);
        end
        rise_seen <= rise_seen | rise_hit;
        fall_seen <= fall_seen | fall_hit;
      end
    end
  end

  assign mon.locked      = locked;
  assign mon.err_pulse   = err_pulse;
  assign mon.err_sticky  = err_sticky;
  assign mon.err_count   = err_count;
  assign mon.wrap_count  = wrap_count;
  assign mon.rise_seen   = rise_seen;
  assign mon.fall_seen   = fall_seen;
  assign mon.full_toggle = (&rise_seen) & (&fall_seen);

endmodule
